// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product / quotient+remainder for mult, multu, div, divu.
// valid drops for division by zero so the caller can leave HI/LO untouched.
module md_calc
  import md_pkg::*;
(
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] smul;
  logic [63:0] umul;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] qm;
  logic [31:0] rm;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        b_zero;
  logic        ovf;

  // Low 64 bits of the product of sign-extended operands are the signed product.
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};

  // Signed division on magnitudes keeps the simulator away from INT_MIN / -1.
  assign ma = a[31] ? (32'd0 - a) : a;
  assign mb = b[31] ? (32'd0 - b) : b;
  assign qm = ma / mb;
  assign rm = ma % mb;
  assign sq = (a[31] ^ b[31]) ? (32'd0 - qm) : qm;
  assign sr = a[31] ? (32'd0 - rm) : rm;

  assign uq = a / b;
  assign ur = a % b;

  assign b_zero = (b == 32'd0);
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    valid = 1'b1;
    hi    = 32'd0;
    lo    = 32'd0;
    case (mdop)
      MD_MULT: begin
        hi = smul[63:32];
        lo = smul[31:0];
      end
      MD_MULTU: begin
        hi = umul[63:32];
        lo = umul[31:0];
      end
      MD_DIV: begin
        if (b_zero) begin
          valid = 1'b0;
        end else if (ovf) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          hi = sr;
          lo = sq;
        end
      end
      default: begin
        if (b_zero) begin
          valid = 1'b0;
        end else begin
          hi = ur;
          lo = uq;
        end
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency md ops, mthi/mtlo.
// state | meaning
// IDLE  | Busy=0; accepts Start or mthi/mtlo writes
// RUN   | Busy=1; cnt counts down, result commits when cnt reaches 1
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWe,
  input  logic        LOWe,
  input  logic        RdSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int CNT_MAX = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic [31:0]      phi;
  logic [31:0]      plo;
  logic             pvalid;
  logic             calc_valid;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             start_ok;
  logic             commit;

  md_calc u_calc (
    .mdop  (MDOp),
    .a     (A),
    .b     (B),
    .valid (calc_valid),
    .hi    (calc_hi),
    .lo    (calc_lo)
  );

  assign cnt_load = is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        if (cnt == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      phi    <= 32'd0;
      plo    <= 32'd0;
      pvalid <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      if (start_ok) begin
        phi    <= calc_hi;
        plo    <= calc_lo;
        pvalid <= calc_valid;
        cnt    <= cnt_load;
      end else if (state_q == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A zero-divisor op runs its full latency but leaves HI/LO alone.
      if (commit && pvalid) begin
        HI <= phi;
        LO <= plo;
      end else if ((state_q == IDLE) && !Start) begin
        if (HIWe) HI <= A;
        if (LOWe) LO <= A;
      end
    end
  end

  assign Busy = (state_q == RUN);
  assign Out  = RdSel ? HI : LO;

endmodule
